// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - ID/EX consumer-side hazard control: load-use stalls, flushes, forwarding, perf counters
// State advances on the falling edge, matching the pipeline registers it steers.
module ex_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken_ex,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  logic [2:0] remaining;
  logic       lu_haz;
  logic       stall_inc;
  logic       flush_inc;

  assign lu_haz = idex_mem_read && (idex_rt != 5'd0) &&
                  ((id_uses_rs && (idex_rt == id_rs)) ||
                   (id_uses_rt && (idex_rt == id_rt)));

  // Control outputs; a taken branch overrides everything, including an ongoing stall.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (state == LU_STALL || lu_haz) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
      stall_inc     = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs)
        fwd_a = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs)
        fwd_a = 2'b01;
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rt)
        fwd_b = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rt)
        fwd_b = 2'b01;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      remaining   <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
      if (flush_inc && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
      case (state)
        RUN: begin
          if (!branch_taken_ex && lu_haz && LU_STALL_CYCLES > 1) begin
            state     <= LU_STALL;
            remaining <= LU_INIT;
          end
        end
        LU_STALL: begin
          if (branch_taken_ex) begin
            state     <= RUN;
            remaining <= 3'd0;
          end else begin
            remaining <= remaining - 3'd1;
            if (remaining <= 3'd1)
              state <= RUN;
          end
        end
        default: begin
          state     <= RUN;
          remaining <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

  logic       clk = 1'b1;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_jump = 0;
  logic       idex_mem_read = 0;
  logic [4:0] idex_rs = '0, idex_rt = '0;
  logic       branch_taken_ex = 0;
  logic       exmem_reg_write = 0, memwb_reg_write = 0;
  logic [4:0] exmem_rd = '0, memwb_rd = '0;

  logic        a_pc, a_ifw, a_flush, a_bubble;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_stall_count, a_flush_count;
  logic        b_pc, b_ifw, b_flush, b_bubble;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [1:0]  b_stall_count, b_flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .idex_mem_read(idex_mem_read), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .branch_taken_ex(branch_taken_ex), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .pc_write_en(a_pc), .ifid_write_en(a_ifw), .ifid_flush(a_flush),
    .idex_bubble(a_bubble), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  ex_hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .idex_mem_read(idex_mem_read), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .branch_taken_ex(branch_taken_ex), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .pc_write_en(b_pc), .ifid_write_en(b_ifw), .ifid_flush(b_flush),
    .idex_bubble(b_bubble), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    idex_mem_read = 0; idex_rs = '0; idex_rt = '0; branch_taken_ex = 0;
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = '0; memwb_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic set_lu_haz();
    idex_mem_read = 1; idex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    exmem_reg_write = 1; exmem_rd = 5'd3; idex_rs = 5'd3; idex_rt = 5'd3;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_pc, a_ifw, a_flush, a_bubble} !== 4'b0011) begin
      failures++; $display("FAIL reset_ctrl_a: got %b want 0011", {a_pc, a_ifw, a_flush, a_bubble});
    end
    checks++;
    if ({b_pc, b_ifw, b_flush, b_bubble} !== 4'b0011) begin
      failures++; $display("FAIL reset_ctrl_b: got %b want 0011", {b_pc, b_ifw, b_flush, b_bubble});
    end
    checks++;
    if ({a_fwd_a, a_fwd_b} !== 4'b0000) begin
      failures++; $display("FAIL reset_fwd: got %b want 0000", {a_fwd_a, a_fwd_b});
    end
    checks++;
    if (a_stall_count !== 16'd0 || a_flush_count !== 16'd0 || b_stall_count !== 2'd0 || b_flush_count !== 2'd0) begin
      failures++; $display("FAIL reset_counts: got %0d %0d %0d %0d want 0 0 0 0",
                           a_stall_count, a_flush_count, b_stall_count, b_flush_count);
    end
    #2 reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    checks++;
    if ({a_pc, a_ifw, a_flush, a_bubble} !== 4'b1100) begin
      failures++; $display("FAIL idle_run: got %b want 1100", {a_pc, a_ifw, a_flush, a_bubble});
    end
  endtask

  task automatic test_lu_single();
    do_reset();
    set_lu_haz();
    @(posedge clk); #1;
    checks++;
    if ({a_pc, a_ifw, a_bubble, a_flush} !== 4'b0010) begin
      failures++; $display("FAIL lu1_stall: got %b want 0010", {a_pc, a_ifw, a_bubble, a_flush});
    end
    @(negedge clk); #1;
    idex_mem_read = 0;
    #1;
    checks++;
    if (a_pc !== 1'b1 || a_bubble !== 1'b0) begin
      failures++; $display("FAIL lu1_release: got pc=%b bubble=%b want 1 0", a_pc, a_bubble);
    end
    checks++;
    if (a_stall_count !== 16'd1) begin
      failures++; $display("FAIL lu1_count: got %0d want 1", a_stall_count);
    end
  endtask

  task automatic test_lu_multi();
    do_reset();
    set_lu_haz();
    id_jump = 1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (b_pc !== 1'b0 || b_bubble !== 1'b1 || b_flush !== 1'b0) begin
        failures++; $display("FAIL lu3_stall_c%0d: got pc=%b bubble=%b flush=%b want 0 1 0", c, b_pc, b_bubble, b_flush);
      end
      @(negedge clk); #1;
      idex_mem_read = 0;
    end
    @(posedge clk); #1;
    checks++;
    if (b_pc !== 1'b1 || b_flush !== 1'b1) begin
      failures++; $display("FAIL lu3_deferred_jump: got pc=%b flush=%b want 1 1", b_pc, b_flush);
    end
    checks++;
    if (b_stall_count !== 2'd3) begin
      failures++; $display("FAIL lu3_count: got %0d want 3", b_stall_count);
    end
    checks++;
    if (a_stall_count !== 16'd1) begin
      failures++; $display("FAIL lu3_count_a: got %0d want 1", a_stall_count);
    end
    @(negedge clk); #1;
    id_jump = 0;
    checks++;
    if (b_flush_count !== 2'd1) begin
      failures++; $display("FAIL lu3_jump_count: got %0d want 1", b_flush_count);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_lu_haz();
    branch_taken_ex = 1;
    @(posedge clk); #1;
    checks++;
    if ({a_pc, a_ifw, a_flush, a_bubble} !== 4'b1111) begin
      failures++; $display("FAIL br_lu_ctrl: got %b want 1111", {a_pc, a_ifw, a_flush, a_bubble});
    end
    @(negedge clk); #1;
    clear_inputs();
    #1;
    checks++;
    if (a_stall_count !== 16'd0 || a_flush_count !== 16'd1) begin
      failures++; $display("FAIL br_lu_counts: got stall=%0d flush=%0d want 0 1", a_stall_count, a_flush_count);
    end
    checks++;
    if (b_pc !== 1'b1 || b_stall_count !== 2'd0 || b_flush_count !== 2'd1) begin
      failures++; $display("FAIL br_lu_b: got pc=%b stall=%0d flush=%0d want 1 0 1", b_pc, b_stall_count, b_flush_count);
    end
  endtask

  task automatic test_fwd();
    do_reset();
    exmem_reg_write = 1; memwb_reg_write = 1; exmem_rd = 5'd3; memwb_rd = 5'd3; idex_rs = 5'd3;
    #1;
    checks++;
    if (a_fwd_a !== 2'b10) begin
      failures++; $display("FAIL fwd_a_exmem: got %b want 10", a_fwd_a);
    end
    exmem_reg_write = 0;
    #1;
    checks++;
    if (a_fwd_a !== 2'b01) begin
      failures++; $display("FAIL fwd_a_memwb: got %b want 01", a_fwd_a);
    end
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = 5'd0;
    #1;
    checks++;
    if (a_fwd_a !== 2'b00) begin
      failures++; $display("FAIL fwd_a_r0: got %b want 00", a_fwd_a);
    end
    idex_rt = 5'd7; exmem_rd = 5'd7; memwb_rd = 5'd7;
    #1;
    checks++;
    if (a_fwd_b !== 2'b10 || a_fwd_a !== 2'b00) begin
      failures++; $display("FAIL fwd_b_exmem: got b=%b a=%b want 10 00", a_fwd_b, a_fwd_a);
    end
    exmem_rd = 5'd8;
    #1;
    checks++;
    if (a_fwd_b !== 2'b01) begin
      failures++; $display("FAIL fwd_b_memwb: got %b want 01", a_fwd_b);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_lu_haz();
    @(negedge clk); #1;
    idex_mem_read = 0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({b_pc, b_ifw, b_flush, b_bubble} !== 4'b0011 || b_stall_count !== 2'd0) begin
      failures++; $display("FAIL mid_reset: got %b stall=%0d want 0011 0", {b_pc, b_ifw, b_flush, b_bubble}, b_stall_count);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b_pc !== 1'b1 || b_bubble !== 1'b0) begin
      failures++; $display("FAIL mid_reset_run: got pc=%b bubble=%b want 1 0", b_pc, b_bubble);
    end
    @(negedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (b_pc !== 1'b1 || b_stall_count !== 2'd0 || b_flush_count !== 2'd0) begin
      failures++; $display("FAIL mid_reset_after: got pc=%b stall=%0d flush=%0d want 1 0 0", b_pc, b_stall_count, b_flush_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_jump = 1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      checks++;
      if (b_flush !== 1'b1 || b_pc !== 1'b1 || b_bubble !== 1'b0) begin
        failures++; $display("FAIL jump_%0d: got flush=%b pc=%b bubble=%b want 1 1 0", j, b_flush, b_pc, b_bubble);
      end
      @(negedge clk);
    end
    #1;
    id_jump = 0;
    checks++;
    if (b_flush_count !== 2'd3) begin
      failures++; $display("FAIL jump_sat: got %0d want 3", b_flush_count);
    end
    checks++;
    if (a_flush_count !== 16'd5) begin
      failures++; $display("FAIL jump_count_a: got %0d want 5", a_flush_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lu_single();
    test_lu_multi();
    test_branch_lu();
    test_fwd();
    test_reset_mid_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
